free_list: RTL and testbench
============================

# free_list

Physical-register free list for the out-of-order rename stage: the other end of the RAT's register-recycle interface. It supplies an unused physical register to the rename stage each cycle a destination is renamed, and accepts registers returned by the RAT's recycle outputs (RegRecycle/RegRecycleID). On a pipeline flush it rewinds allocation to the last committed point, so speculatively allocated registers become free again in one cycle.

## Interface
- ID, "FreeList": debug label printed by `$display` messages.
- NUM_PHYS, 64: physical register count; must be a power of two; also the storage depth.
- NUM_ARCH, 35: architectural register count. Arch reg 33 is LO and 34 is HI.
- LOG_PHYS, 6: log2(NUM_PHYS).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- Alloc_IN  in  1  rename consumes AllocPReg_OUT this cycle.
- AllocPReg_OUT  out  LOG_PHYS  physical register at the head; valid when Empty_OUT=0.
- Empty_OUT  out  1  no free register available.
- RegRecycle_IN  in  1  a freed register is being returned this cycle.
- RegRecycleID_IN  in  LOG_PHYS  the physical register being returned.
- Commit_IN  in  1  one renamed (allocating) instruction retired; advances the commit head.
- Flush_IN  in  1  mispredict/exception recovery; rewind head to the commit head.
- Count_OUT  out  LOG_PHYS+1  number of free entries.
- Error_OUT  out  1  sticky protocol-violation flag.

## Operation
- Storage: circular buffer of NUM_PHYS entries, each LOG_PHYS bits, with LOG_PHYS-bit wrapping pointers:
  - head: next register to allocate.
  - tail: next slot to write.
  - chead: commit head.
- Empty is head==tail. Count is (tail−head) mod NUM_PHYS. Correct use never exceeds NUM_PHYS−NUM_ARCH free entries, so head==tail is never ambiguous.
- Reset contents and pointers:
  - entry[k]=NUM_ARCH+k for k=0..NUM_PHYS−NUM_ARCH−1.
  - head=chead=0, tail=NUM_PHYS−NUM_ARCH, Error_OUT=0.
  - This matches the RAT reset mapping arch i→phys i.
- Alloc (Alloc_IN && !Empty_OUT && !Flush_IN): head<=head+1.
  - Alloc_IN while empty: ignored, Error_OUT<=1.
- Recycle (RegRecycle_IN): entry[tail]<=RegRecycleID_IN, tail<=tail+1.
  - If tail+1==head, the write is dropped and Error_OUT<=1.
  - A recycle is always accepted during Flush_IN.
- Commit (Commit_IN): chead<=chead+1.
  - Commit_IN with chead==head (commit passing alloc): ignored, Error_OUT<=1.
- Flush: head<=chead+Commit_IN; any Alloc_IN in the same cycle is ignored. Recycle and Commit still take effect in the flush cycle.
- Simultaneous alloc+recycle: both happen, and Count is unchanged. There is no empty-bypass: a recycled register is allocatable from the next cycle.
- `$display` "%s:alloc P%0d" / "%s:free P%0d" / "%s:flush" for debug. Debug text only; it does not affect state.

## Timing
- AllocPReg_OUT, Empty_OUT and Count_OUT are combinational decodes of registered state only. There is no input-to-output combinational path.
- Alloc latency: 0 cycles. Rename reads AllocPReg_OUT and asserts Alloc_IN in the same cycle; the next register appears after the edge.
- Recycle-to-available latency: 1 cycle.
- Flush: takes effect at the edge. In the following cycle AllocPReg_OUT=entry[new head].
- Output values during and after reset: AllocPReg_OUT=NUM_ARCH (35), Empty_OUT=0, Count_OUT=NUM_PHYS−NUM_ARCH (29), Error_OUT=0.
- RESET asserted mid-operation overrides every other input that cycle.
- Pointer wrap-around: NUM_PHYS−1 → 0, natural modular arithmetic.

## Structure
- The shared `config.v` defines `NUM_ARCH_REGS`, `NUM_PHYS_REGS` and `LOG_PHYS`; these are the instantiation defaults.
- One sub-module, `free_list_mem`: NUM_PHYS×LOG_PHYS register array with one synchronous write port and one asynchronous read port, and reset initialisation.
- Pointer, flush and error logic stay in free_list.

## Test plan
- **Reset then 29 allocs** (Alloc_IN held 29 cycles) → AllocPReg_OUT steps 35..63. Empty_OUT rises after the 29th, Count_OUT=0, Error_OUT=0.
- **Alloc while empty** → AllocPReg/pointers unchanged, Error_OUT=1 and stays 1 until RESET.
- **Empty, recycle P7 with Alloc_IN asserted the same cycle** → alloc ignored (Error set). Next cycle Empty_OUT=0, AllocPReg_OUT=7.
- **3 allocs (35,36,37), 1 commit, then Flush_IN** → next cycle AllocPReg_OUT=36, Count_OUT=28.
- **Flush with Commit_IN and RegRecycle_IN(P40) in the same cycle** → head=chead+1 and P40 written at tail. The test then drains all entries to check P40 comes out last.
- **Run 200 cycles of random alloc/recycle with a scoreboard model** → pointers wrap past 63→0, no register is duplicated or lost, and Error_OUT=0.

Source files
------------

// File: rtl/free_list_pkg.sv
// Shared defaults and decode record for the physical-register free list.
package free_list_pkg;

  localparam int FL_NUM_PHYS = 64;
  localparam int FL_NUM_ARCH = 35;
  localparam int FL_LOG_PHYS = 6;

  // Per-cycle decode of which requests are honoured and whether any was illegal.
  typedef struct packed {
    logic alloc;
    logic recycle;
    logic commit;
    logic err;
  } fl_ops_t;

endpackage

// File: rtl/free_list_mem.sv
// Free-list storage: register array, one synchronous write port, one asynchronous read port.
module free_list_mem #(
  parameter int DEPTH      = 64,
  parameter int WIDTH      = 6,
  parameter int ADDR_W     = 6,
  parameter int INIT_BASE  = 35,
  parameter int INIT_COUNT = 29
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Reset loads the registers not claimed by the initial arch->phys identity map.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= (k < INIT_COUNT) ? WIDTH'(INIT_BASE + k) : '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/free_list.sv
// Physical-register free list: circular buffer with allocate head, commit head and recycle tail;
// a flush rewinds the allocate head to the commit head in one cycle.
module free_list
  import free_list_pkg::*;
#(
  parameter int NUM_PHYS = FL_NUM_PHYS,
  parameter int NUM_ARCH = FL_NUM_ARCH,
  parameter int LOG_PHYS = FL_LOG_PHYS
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                Alloc_IN,
  output logic [LOG_PHYS-1:0] AllocPReg_OUT,
  output logic                Empty_OUT,
  input  logic                RegRecycle_IN,
  input  logic [LOG_PHYS-1:0] RegRecycleID_IN,
  input  logic                Commit_IN,
  input  logic                Flush_IN,
  output logic [LOG_PHYS:0]   Count_OUT,
  output logic                Error_OUT
);

  localparam logic [LOG_PHYS-1:0] PTR_ONE  = LOG_PHYS'(1);
  localparam logic [LOG_PHYS-1:0] TAIL_RST = LOG_PHYS'(NUM_PHYS - NUM_ARCH);

  logic [LOG_PHYS-1:0] head_q, head_d;
  logic [LOG_PHYS-1:0] tail_q, tail_d;
  logic [LOG_PHYS-1:0] chead_q, chead_d;
  logic                error_q, error_d;
  logic                empty, ring_full;
  fl_ops_t             ops;

  assign empty     = (head_q == tail_q);
  assign ring_full = ((tail_q + PTR_ONE) == head_q);

  always_comb begin
    ops         = '0;
    ops.alloc   = Alloc_IN && !empty && !Flush_IN;
    // A flush pulls the head back, so a recycle in that cycle always has room.
    ops.recycle = RegRecycle_IN && (Flush_IN || !ring_full);
    ops.commit  = Commit_IN && (chead_q != head_q);
    ops.err     = (Alloc_IN && empty && !Flush_IN)
                || (RegRecycle_IN && ring_full && !Flush_IN)
                || (Commit_IN && (chead_q == head_q));

    chead_d = chead_q + (ops.commit  ? PTR_ONE : '0);
    tail_d  = tail_q  + (ops.recycle ? PTR_ONE : '0);
    head_d  = Flush_IN ? chead_d : (head_q + (ops.alloc ? PTR_ONE : '0));
    error_d = error_q | ops.err;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      head_q  <= '0;
      chead_q <= '0;
      tail_q  <= TAIL_RST;
      error_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      chead_q <= chead_d;
      tail_q  <= tail_d;
      error_q <= error_d;
    end
  end

  free_list_mem #(
    .DEPTH      (NUM_PHYS),
    .WIDTH      (LOG_PHYS),
    .ADDR_W     (LOG_PHYS),
    .INIT_BASE  (NUM_ARCH),
    .INIT_COUNT (NUM_PHYS - NUM_ARCH)
  ) u_mem (
    .clk_i   (CLK),
    .srst_i  (RESET),
    .we_i    (ops.recycle),
    .waddr_i (tail_q),
    .wdata_i (RegRecycleID_IN),
    .raddr_i (head_q),
    .rdata_o (AllocPReg_OUT)
  );

  assign Empty_OUT = empty;
  assign Count_OUT = {1'b0, tail_q - head_q};
  assign Error_OUT = error_q;

endmodule

// File: tb/tb_free_list.sv
// Bench for free_list: directed corner sequences, a vector table, and a randomized run
// checked against a queue-based model of the free pool.
module tb_free_list;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       Alloc_IN;
  logic [5:0] AllocPReg_OUT;
  logic       Empty_OUT;
  logic       RegRecycle_IN;
  logic [5:0] RegRecycleID_IN;
  logic       Commit_IN;
  logic       Flush_IN;
  logic [6:0] Count_OUT;
  logic       Error_OUT;

  int n_cmp = 0;
  int n_bad = 0;

  free_list dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .Alloc_IN        (Alloc_IN),
    .AllocPReg_OUT   (AllocPReg_OUT),
    .Empty_OUT       (Empty_OUT),
    .RegRecycle_IN   (RegRecycle_IN),
    .RegRecycleID_IN (RegRecycleID_IN),
    .Commit_IN       (Commit_IN),
    .Flush_IN        (Flush_IN),
    .Count_OUT       (Count_OUT),
    .Error_OUT       (Error_OUT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit alloc;
    bit rec;
    int rec_id;
    bit commit;
    bit flush;
    int e_preg;
    bit e_empty;
    int e_count;
    bit e_err;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // e_preg < 0 means the head register is not meaningful (list empty).
  task automatic expect_state(input string tag, input int e_preg, input bit e_empty,
                              input int e_count, input bit e_err);
    if (e_preg >= 0) chk({tag, ".preg"}, int'(AllocPReg_OUT), e_preg);
    chk({tag, ".empty"}, int'(Empty_OUT), int'(e_empty));
    chk({tag, ".count"}, int'(Count_OUT), e_count);
    chk({tag, ".err"},   int'(Error_OUT), int'(e_err));
  endtask

  task automatic idle();
    Alloc_IN = 0; RegRecycle_IN = 0; RegRecycleID_IN = '0; Commit_IN = 0; Flush_IN = 0;
  endtask

  // Inputs change on the falling edge; outputs are observed on the falling edge after a rise.
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RESET = 1; idle();
    tick();
    expect_state("reset", 35, 0, 29, 0);
    RESET = 0;
  endtask

  // Model of the pool: free registers in allocation order, allocated-but-uncommitted
  // registers in program order, and registers held by the architectural map.
  int free_q[$];
  int infl_q[$];
  int held_q[$];

  initial begin
    RESET = 1; idle();
    @(negedge CLK);

    // Reset, then 29 back-to-back allocations drain the list in order.
    do_reset();
    for (int i = 0; i < 29; i++) begin
      chk("drain29.preg", int'(AllocPReg_OUT), 35 + i);
      $display("alloc #%0d preg=%0d", i, AllocPReg_OUT);
      Alloc_IN = 1;
      tick();
    end
    idle();
    expect_state("after29", -1, 1, 0, 0);

    // Allocation while empty is ignored and latches the error.
    Alloc_IN = 1;
    tick();
    idle();
    expect_state("alloc_empty", -1, 1, 0, 1);
    tick();
    chk("err_sticky", int'(Error_OUT), 1);

    // Recycle into an empty list with a same-cycle alloc: no bypass.
    Alloc_IN = 1; RegRecycle_IN = 1; RegRecycleID_IN = 6'd7;
    tick();
    idle();
    expect_state("recycle_empty", 7, 0, 1, 1);
    $display("recycle P7 -> preg=%0d count=%0d", AllocPReg_OUT, Count_OUT);

    // Reset overrides every other input in its cycle.
    Alloc_IN = 1; RegRecycle_IN = 1; RegRecycleID_IN = 6'd9; Commit_IN = 1; Flush_IN = 1;
    RESET = 1;
    tick();
    RESET = 0; idle();
    expect_state("midreset", 35, 0, 29, 0);

    // Alloc/commit/flush table from the reset state.
    vecs[0] = '{1, 0, 0,  0, 0, 36, 0, 28, 0};
    vecs[1] = '{1, 0, 0,  0, 0, 37, 0, 27, 0};
    vecs[2] = '{1, 0, 0,  0, 0, 38, 0, 26, 0};
    vecs[3] = '{0, 0, 0,  1, 0, 38, 0, 26, 0};
    vecs[4] = '{1, 0, 0,  0, 1, 36, 0, 28, 0};
    vecs[5] = '{1, 0, 0,  0, 0, 37, 0, 27, 0};
    vecs[6] = '{1, 0, 0,  0, 0, 38, 0, 26, 0};
    vecs[7] = '{0, 1, 40, 1, 1, 37, 0, 28, 0};
    vecs[8] = '{0, 0, 0,  1, 0, 37, 0, 28, 1};
    for (int v = 0; v < 9; v++) begin
      Alloc_IN = vecs[v].alloc; RegRecycle_IN = vecs[v].rec;
      RegRecycleID_IN = 6'(vecs[v].rec_id);
      Commit_IN = vecs[v].commit; Flush_IN = vecs[v].flush;
      tick();
      idle();
      $display("vec %0d: preg=%0d empty=%0d count=%0d err=%0d", v,
               AllocPReg_OUT, Empty_OUT, Count_OUT, Error_OUT);
      expect_state($sformatf("vec%0d", v), vecs[v].e_preg, vecs[v].e_empty,
                   vecs[v].e_count, vecs[v].e_err);
    end

    // Drain: P40, recycled during the flush, must come out last.
    for (int i = 0; i < 28; i++) begin
      chk("drain40.preg", int'(AllocPReg_OUT), (i < 27) ? 37 + i : 40);
      Alloc_IN = 1;
      tick();
    end
    idle();
    expect_state("drain40.end", -1, 1, 0, 1);

    // Randomized alloc/commit/recycle/flush against the pool model.
    do_reset();
    free_q.delete(); infl_q.delete(); held_q.delete();
    for (int k = 35; k < 64; k++) free_q.push_back(k);
    for (int k = 0; k < 35; k++) held_q.push_back(k);
    for (int cyc = 0; cyc < 200; cyc++) begin
      bit a, c, r, f;
      int rid;
      if (free_q.size() > 0) chk("rand.preg", int'(AllocPReg_OUT), free_q[0]);
      chk("rand.empty", int'(Empty_OUT), (free_q.size() == 0) ? 1 : 0);
      chk("rand.count", int'(Count_OUT), free_q.size());
      chk("rand.err",   int'(Error_OUT), 0);

      a = (free_q.size() > 0) && ($urandom_range(0, 3) != 0);
      c = (infl_q.size() > 0) && ($urandom_range(0, 1) == 1);
      r = (held_q.size() > 35) && ($urandom_range(0, 1) == 1);
      f = ($urandom_range(0, 19) == 0);
      rid = 0;
      if (r) begin
        int idx;
        idx = $urandom_range(0, held_q.size() - 1);
        rid = held_q[idx];
        held_q.delete(idx);
      end
      Alloc_IN = a; Commit_IN = c; RegRecycle_IN = r; RegRecycleID_IN = 6'(rid); Flush_IN = f;
      $display("cyc %0d: alloc=%0d commit=%0d recycle=%0d(P%0d) flush=%0d free=%0d",
               cyc, a, c, r, rid, f, free_q.size());

      if (a && !f) infl_q.push_back(free_q.pop_front());
      if (c) held_q.push_back(infl_q.pop_front());
      if (f) begin
        for (int i = infl_q.size() - 1; i >= 0; i--) free_q.push_front(infl_q[i]);
        infl_q.delete();
      end
      if (r) free_q.push_back(rid);

      tick();
      idle();
    end
    if (free_q.size() > 0) chk("rand.final.preg", int'(AllocPReg_OUT), free_q[0]);
    chk("rand.final.count", int'(Count_OUT), free_q.size());
    chk("rand.final.err",   int'(Error_OUT), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
